// File: rtl/imem_buf_pkg.sv
// Shared types and helpers for the two-entry instruction line buffer.
// Line geometry is fixed at 256 bits (eight 32-bit words).
package imem_buf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    PREF
  } state_t;

  localparam int ADDR_W         = 32;
  localparam int LINE_BYTES     = 32;
  localparam int WORDS_PER_LINE = 8;
  localparam int TAG_WIDTH      = ADDR_W - 5;

  // Word 0 sits in the top 32 bits: byte at the line base is bits [255:248].
  function automatic logic [31:0] line_word(
    input logic [255:0] line,
    input logic [2:0]   idx
  );
    logic [7:0] base;
    base      = 8'd255 - {idx, 5'd0};
    line_word = line[base -: 32];
  endfunction

endpackage

// File: rtl/imem_line_entry.sv
// One resident line: valid bit, tag and data with lookup compares
// for the demand address and the prefetch candidate.
module imem_line_entry
  import imem_buf_pkg::*;
#(
  parameter int TW = TAG_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en,
  input  logic           inv,
  input  logic [TW-1:0]  wr_tag,
  input  logic [255:0]   wr_data,
  input  logic [TW-1:0]  rd_tag,
  input  logic [TW-1:0]  pf_tag,
  input  logic [2:0]     idx,
  output logic           hit,
  output logic           pf_match,
  output logic [31:0]    word
);

  logic          valid;
  logic [TW-1:0] tag;
  logic [255:0]  data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else begin
      if (wr_en) begin
        valid <= 1'b1;
        tag   <= wr_tag;
        data  <= wr_data;
      end
      if (inv) valid <= 1'b0;
    end
  end

  assign hit      = valid && (tag == rd_tag);
  assign pf_match = valid && (tag == pf_tag);
  assign word     = line_word(data, idx);

endmodule

// File: rtl/imem_line_buffer.sv
// Two-entry instruction line buffer: zero-latency hits, line fills on
// miss, optional sequential next-line prefetch into the other entry.
module imem_line_buffer
  import imem_buf_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 256,
  parameter int PREFETCH_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p_strobe_i,
  input  logic [ADDR_WIDTH-1:0] p_addr_i,
  output logic [31:0]           p_instr_o,
  output logic                  p_ready_o,
  input  logic                  flush_i,
  output logic                  m_strobe_o,
  output logic [ADDR_WIDTH-1:0] m_addr_o,
  input  logic [DATA_WIDTH-1:0] m_rdata_i,
  input  logic                  m_done_i
);

  localparam int TW = ADDR_WIDTH - 5;

  state_t        state;
  logic          lru;
  logic          tgt;
  logic          discard;
  logic [1:0]    hit;
  logic [1:0]    pf_match;
  logic [1:0]    wr_en;
  logic [31:0]   word [2];
  logic [TW-1:0] req_tag;
  logic [TW-1:0] fill_tag;
  logic [TW-1:0] next_tag;
  logic          done_x;
  logic          pf_ok;
  logic          miss;
  logic          unused_bits;

  assign unused_bits = ^p_addr_i[1:0];

  assign req_tag   = p_addr_i[ADDR_WIDTH-1:5];
  assign fill_tag  = m_addr_o[ADDR_WIDTH-1:5];
  assign next_tag  = fill_tag + TW'(1);

  assign p_ready_o = p_strobe_i && (|hit) && !flush_i;
  assign p_instr_o = hit[1] ? word[1] : word[0];
  assign miss      = p_strobe_i && !p_ready_o;

  // Done only counts while our own request is on the bus.
  assign done_x   = m_done_i && m_strobe_o && (state != IDLE);
  assign wr_en[0] = done_x && !discard && !flush_i && !tgt;
  assign wr_en[1] = done_x && !discard && !flush_i && tgt;

  assign pf_ok = (PREFETCH_EN != 0) && !pf_match[~tgt] && !(&fill_tag);

  for (genvar i = 0; i < 2; i++) begin : g_ent
    imem_line_entry #(
      .TW(TW)
    ) u_ent (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en[i]),
      .inv      (flush_i),
      .wr_tag   (fill_tag),
      .wr_data  (m_rdata_i[255:0]),
      .rd_tag   (req_tag),
      .pf_tag   (next_tag),
      .idx      (p_addr_i[4:2]),
      .hit      (hit[i]),
      .pf_match (pf_match[i]),
      .word     (word[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lru        <= 1'b0;
      tgt        <= 1'b0;
      discard    <= 1'b0;
      m_strobe_o <= 1'b0;
      m_addr_o   <= '0;
    end else begin
      if (p_ready_o) lru <= hit[0];
      if (flush_i && state != IDLE) discard <= 1'b1;
      unique case (state)
        IDLE: begin
          if (miss) begin
            state      <= FILL;
            m_strobe_o <= 1'b1;
            m_addr_o   <= {req_tag, 5'b0};
            tgt        <= lru;
            discard    <= 1'b0;
          end
        end
        FILL: begin
          if (done_x) begin
            m_strobe_o <= 1'b0;
            if (discard || flush_i) begin
              state   <= IDLE;
              discard <= 1'b0;
            end else begin
              lru <= ~tgt;
              if (pf_ok) begin
                state    <= PREF;
                m_addr_o <= m_addr_o + ADDR_WIDTH'(LINE_BYTES);
                tgt      <= ~tgt;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        PREF: begin
          // Strobe rises one cycle late so it never follows a done.
          if (!m_strobe_o) begin
            m_strobe_o <= 1'b1;
          end else if (done_x) begin
            m_strobe_o <= 1'b0;
            state      <= IDLE;
            discard    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_line_buffer.sv
// Directed bench for imem_line_buffer with a latency-programmable
// line memory model and a request log.
module tb_imem_line_buffer;

  logic         clk;
  logic         rst_n;
  logic         p_strobe;
  logic [31:0]  p_addr;
  logic [31:0]  p_instr;
  logic         p_ready;
  logic         flush;
  logic         m_strobe;
  logic [31:0]  m_addr;
  logic [255:0] m_rdata;
  logic         m_done;

  int n_chk;
  int n_pass;
  int lat;
  int cnt;
  int n_req;
  int n_done;
  int viol;
  logic strobe_q;
  logic [31:0] req_log [$];
  logic [31:0] rdy_maddr;
  logic        rdy_mstrobe;

  imem_line_buffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .p_strobe_i (p_strobe),
    .p_addr_i   (p_addr),
    .p_instr_o  (p_instr),
    .p_ready_o  (p_ready),
    .flush_i    (flush),
    .m_strobe_o (m_strobe),
    .m_addr_o   (m_addr),
    .m_rdata_i  (m_rdata),
    .m_done_i   (m_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] wval(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [255:0] mk_line(input logic [31:0] a);
    logic [255:0] l;
    l = '0;
    for (int w = 0; w < 8; w++)
      l[255 - 32*w -: 32] = wval(a + 32'(4*w));
    return l;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  // Memory model: counts strobe cycles, answers with a one-cycle done.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_done   = 1'b0;
      cnt      = 0;
      strobe_q = 1'b0;
    end else begin
      if (m_done && m_strobe) viol++;
      if (m_strobe && !strobe_q) begin
        req_log.push_back(m_addr);
        n_req++;
      end
      strobe_q = m_strobe;
      if (m_done) begin
        m_done = 1'b0;
      end else if (m_strobe) begin
        cnt++;
        if (cnt >= lat) begin
          m_done  = 1'b1;
          m_rdata = mk_line(m_addr);
          cnt     = 0;
          n_done++;
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] a, output logic [31:0] ins,
                       output int cyc);
    bit got;
    p_strobe = 1'b1;
    p_addr   = a;
    cyc      = 0;
    ins      = '0;
    got      = 1'b0;
    while (!got && cyc < 400) begin
      #1;
      if (p_ready) begin
        got         = 1'b1;
        ins         = p_instr;
        rdy_maddr   = m_addr;
        rdy_mstrobe = m_strobe;
      end
      @(negedge clk);
      if (!got) cyc++;
    end
    if (!got) chk("fetch_timeout", 32'(cyc), 32'd0);
    p_strobe = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int c;
    c = 0;
    while (n_done < target && c < 500) begin
      @(negedge clk);
      c++;
    end
    if (n_done < target) chk("done_timeout", 32'(n_done), 32'(target));
    repeat (2) @(negedge clk);
  endtask

  logic [31:0] ins;
  int          cyc;
  int          rb;
  int          db;

  initial begin
    clk = 0; rst_n = 0; p_strobe = 0; p_addr = '0; flush = 0;
    m_done = 0; m_rdata = '0; lat = 80;
    n_chk = 0; n_pass = 0; n_req = 0; n_done = 0; viol = 0; cnt = 0;
    strobe_q = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_strobe", 32'(m_strobe), 32'd0);
    chk("rst_addr", m_addr, 32'h0);
    chk("rst_ready", 32'(p_ready), 32'd0);
    rst_n = 1;
    @(negedge clk);

    // Cold miss with a long memory, then a prefetch of the next line.
    fetch(32'h8000_0004, ins, cyc);
    lat = 4;
    chk("cold_instr", ins, 32'h0004_FFFB);
    chk("cold_req", req_log[0], 32'h8000_0000);
    chk("cold_lat", 32'(cyc >= 80), 32'd1);
    chk("rdy_pf_addr", rdy_maddr, 32'h8000_0020);
    chk("rdy_pf_strobe", 32'(rdy_mstrobe), 32'd0);
    chk("pf_strobe", 32'(m_strobe), 32'd1);
    chk("pf_addr", m_addr, 32'h8000_0020);
    wait_done(2);

    // Sequential walk across both resident lines.
    for (int i = 0; i < 16; i++) begin
      fetch(32'h8000_0000 + 32'(4*i), ins, cyc);
      chk("seq_instr", ins, wval(32'h8000_0000 + 32'(4*i)));
      chk("seq_lat", 32'(cyc), 32'd0);
    end
    chk("seq_reqs", 32'(n_req), 32'd2);

    // Demand miss while a prefetch is in flight.
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    lat = 20;
    rb = n_req;
    db = n_done;
    fetch(32'h8000_0000, ins, cyc);
    chk("refill_instr", ins, 32'h0000_FFFF);
    fetch(32'h8000_0100, ins, cyc);
    chk("pfwait_instr", ins, 32'h0100_FEFF);
    chk("pfwait_req0", req_log[rb + 1], 32'h8000_0020);
    chk("pfwait_req1", req_log[rb + 2], 32'h8000_0100);
    chk("pfwait_nreq", 32'(n_req - rb), 32'd3);
    fetch(32'h8000_0008, ins, cyc);
    chk("victim_instr", ins, 32'h0008_FFF7);
    chk("victim_lat", 32'(cyc), 32'd0);
    wait_done(db + 4);
    chk("pf2_req", req_log[rb + 3], 32'h8000_0120);

    // Flush while a fill is outstanding.
    lat = 6;
    rb = n_req;
    db = n_done;
    fork
      fetch(32'h8000_0040, ins, cyc);
      begin
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
    join
    chk("flush_instr", ins, 32'h0040_FFBF);
    chk("flush_req0", req_log[rb], 32'h8000_0040);
    chk("flush_req1", req_log[rb + 1], 32'h8000_0040);
    wait_done(db + 3);
    chk("flush_pf", req_log[rb + 2], 32'h8000_0060);

    // Top-of-memory line must not prefetch past the wrap.
    rb = n_req;
    fetch(32'hFFFF_FFE8, ins, cyc);
    chk("top_instr", ins, 32'hFFE8_0017);
    chk("top_req", req_log[rb], 32'hFFFF_FFE0);
    repeat (10) @(negedge clk);
    chk("top_nreq", 32'(n_req - rb), 32'd1);
    chk("top_idle", 32'(m_strobe), 32'd0);

    // Asynchronous reset in the middle of a fill.
    lat = 30;
    p_strobe = 1'b1;
    p_addr   = 32'h8000_0200;
    repeat (5) @(negedge clk);
    chk("mid_strobe", 32'(m_strobe), 32'd1);
    chk("mid_addr", m_addr, 32'h8000_0200);
    rst_n  = 1'b0;
    p_addr = 32'hFFFF_FFE8;
    #1;
    chk("arst_strobe", 32'(m_strobe), 32'd0);
    chk("arst_ready", 32'(p_ready), 32'd0);
    chk("arst_addr", m_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_inval", 32'(p_ready), 32'd0);
    p_strobe = 1'b0;
    @(negedge clk);

    chk("no_strobe_after_done", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/imem_line_buffer.md
Name: imem_line_buffer

Overview:
- Two-entry, 256-bit instruction line buffer between the fetch stage and the dual-port memory's instruction port (strobe/addr/rdata/done).
- Serves 32-bit instruction reads from resident lines combinationally.
- On a miss, issues one line-aligned memory read.
- After each demand fill, optionally prefetches the sequential next line into the other entry.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 256, line width in bits; fixed to 256 (8 words).
- PREFETCH_EN, 1, 1 enables next-line prefetch, 0 disables it.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- p_strobe_i  input  1  fetch request; held with p_addr_i until p_ready_o.
- p_addr_i  input  ADDR_WIDTH  fetch byte address; bits [1:0] ignored.
- p_instr_o  output  32  instruction word, valid while p_ready_o.
- p_ready_o  output  1  request satisfied this cycle.
- flush_i  input  1  single-cycle pulse; invalidates both entries (fence.i).
- m_strobe_o  output  1  memory read request.
- m_addr_o  output  ADDR_WIDTH  line-aligned read address; low 5 bits are zero.
- m_rdata_i  input  DATA_WIDTH  line data; the byte at m_addr_o is in bits [255:248].
- m_done_i  input  1  line data valid this cycle.

Behaviour:
- Reset (async, rst_n=0): state IDLE; both entries invalid; lru=0; m_strobe_o=0; m_addr_o=0; p_ready_o=0.
- Entry: valid bit, tag = addr[31:5], 256-bit line register.
- Hit: p_strobe_i && valid && tag==p_addr_i[31:5] && !flush_i. Then p_ready_o=1 in the same cycle (zero-latency).
- Word select: w=p_addr_i[4:2]; p_instr_o = line[255-32w -: 32], big-endian byte order as stored.
- On a hit, lru points at the other entry.
- FSM states: IDLE, FILL, PREF.
  - IDLE, demand miss: m_addr_o={p_addr_i[31:5],5'b0}, m_strobe_o=1, go to FILL. Victim = lru entry.
  - FILL: m_strobe_o holds until the edge where m_done_i=1, then clears (low from the next cycle). On that edge, write m_rdata_i and tag into the victim, set valid, lru=other entry.
  - FILL exit: go to PREF if PREFETCH_EN, the next tag is not already resident, and the tag is not all-ones (no wrap to 0). Otherwise go to IDLE.
  - Entering PREF: m_addr_o = filled address+32, m_strobe_o=1, target = the entry not just filled.
  - PREF: on m_done_i, write the target and go to IDLE. lru is unchanged.
- Demand hits are served in every state. A demand miss during PREF waits for PREF to complete, then re-evaluates in IDLE: either a hit, or a fill one cycle later.
- m_strobe_o is never asserted in the cycle after m_done_i. This guarantees the memory returns to IDLE without re-triggering.
- Flush:
  - Clears both valid bits on the edge.
  - p_ready_o is forced 0 that cycle.
  - An in-flight FILL or PREF cannot be aborted. It completes, but its data is discarded (valid stays 0) and no prefetch follows.
  - A pending demand then misses and refills.
- m_done_i outside FILL or PREF is ignored.
- Asynchronous reset mid-transaction returns to IDLE immediately. The memory side is reset by the same rst_n.
- Line index arithmetic is unsigned, modulo 2^27.

Decomposition:
- Shared package imem_buf_pkg holds:
  - state_t enum {IDLE, FILL, PREF}
  - LINE_BYTES=32, WORDS_PER_LINE=8, TAG_WIDTH=ADDR_WIDTH-5
  - function line_word(line, idx) returning the big-endian 32-bit word.
- One sub-module, imem_line_entry: valid/tag/data storage with write, invalidate, hit compare and word extract. Instantiate twice.

Test Plan:
- Cold fetch 0x80000004 with a 0x50-cycle memory -> m_strobe_o=1, m_addr_o=0x80000000 until done.
  - One cycle later p_ready_o=1 with p_instr_o = bytes [4..7] of the line.
  - Then m_addr_o=0x80000020 prefetch.
- Sequential fetch 0x80000000..0x8000003C -> after the first fill, all fetches of 0x80000020-0x8000003C hit without a new strobe once the prefetch is done.
- Fetch 0x80000100 during an active prefetch of 0x80000020 -> no strobe until the prefetch done. Then FILL 0x80000100, victim = lru entry.
- flush_i during FILL of 0x80000040 -> fill completes, entry stays invalid, a second strobe to 0x80000040 follows, and no prefetch.
- Fetch 0xFFFFFFE8 -> fill 0xFFFFFFE0, word 2 returned, no prefetch issued.
- rst_n low mid-FILL -> m_strobe_o=0 and p_ready_o=0 immediately, both entries invalid.
